// File: rtl/dcache_port_arbiter.sv
// -----------------------------------------------------------------------------
// dcache_port_arbiter
//   Shares one D$ request port among NumReq requesters. The winner is chosen
//   by fixed priority (index 0 highest) or round-robin. A request that the
//   cache has seen but not yet accepted stays locked to its requester.
//   Read responses come back in grant order and are steered to the requester
//   recorded in an in-order ID FIFO.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   req_valid_i/we_i      per-requester request valid / write flag
//   req_index_i/tag_i     packed address fields, requester i at [i*W +: W]
//   req_wdata_i/be_i      packed write data / byte enables
//   req_gnt_o             per-requester grant (one-hot or zero)
//   req_rvalid_o          per-requester read-data valid (one-hot or zero)
//   req_rdata_o           read data, broadcast to all requesters
//   cache_req_o, cache_we_o, cache_index_o, cache_tag_o, cache_wdata_o,
//   cache_be_o            request to the cache (fields of the selected requester)
//   cache_gnt_i           cache accepts the request
//   cache_rvalid_i/rdata_i read response from the cache, in grant order
//   rsp_err_o             one-cycle pulse: response arrived with no read pending
// -----------------------------------------------------------------------------
module dcache_port_arbiter #(
  parameter int NumReq         = 2,
  parameter int IdxW           = 12,
  parameter int TagW           = 44,
  parameter int DataW          = 64,
  parameter int RoundRobin     = 0,
  parameter int MaxOutstanding = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NumReq-1:0]           req_valid_i,
  input  logic [NumReq-1:0]           req_we_i,
  input  logic [NumReq*IdxW-1:0]      req_index_i,
  input  logic [NumReq*TagW-1:0]      req_tag_i,
  input  logic [NumReq*DataW-1:0]     req_wdata_i,
  input  logic [NumReq*DataW/8-1:0]   req_be_i,
  output logic [NumReq-1:0]           req_gnt_o,
  output logic [NumReq-1:0]           req_rvalid_o,
  output logic [DataW-1:0]            req_rdata_o,
  output logic                        cache_req_o,
  output logic                        cache_we_o,
  output logic [IdxW-1:0]             cache_index_o,
  output logic [TagW-1:0]             cache_tag_o,
  output logic [DataW-1:0]            cache_wdata_o,
  output logic [DataW/8-1:0]          cache_be_o,
  input  logic                        cache_gnt_i,
  input  logic                        cache_rvalid_i,
  input  logic [DataW-1:0]            cache_rdata_i,
  output logic                        rsp_err_o
);

  localparam int BeW  = DataW / 8;
  localparam int SelW = $clog2(NumReq);
  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntW = $clog2(MaxOutstanding) + 1;

  localparam logic [SelW-1:0] LastIdx = SelW'(NumReq - 1);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);

  logic [SelW-1:0] r_rr_ptr;
  logic            r_lock;
  logic [SelW-1:0] r_owner;
  logic [SelW-1:0] r_fifo [MaxOutstanding];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [CntW-1:0] r_count;
  logic            r_rsp_err;

  logic [SelW-1:0] w_winner;
  logic [SelW-1:0] w_sel;
  logic            w_any;
  logic            w_sel_we;
  logic            w_can_issue;
  logic            w_hs;
  logic            w_push;
  logic            w_pop;

  // Winner search. Loops run from the far end so the last hit is the one
  // closest to the search start (index 0, or rr_ptr in round-robin mode).
  always_comb begin
    logic [SelW-1:0] v_idx;
    w_winner = '0;
    v_idx    = '0;
    if (RoundRobin != 0) begin
      for (int k = NumReq - 1; k >= 0; k--) begin
        v_idx = SelW'((int'(r_rr_ptr) + k) % NumReq);
        if (req_valid_i[v_idx]) w_winner = v_idx;
      end
    end else begin
      for (int i = NumReq - 1; i >= 0; i--) begin
        if (req_valid_i[i]) w_winner = SelW'(i);
      end
    end
  end

  assign w_sel    = r_lock ? r_owner : w_winner;
  assign w_any    = |req_valid_i;
  assign w_sel_we = req_we_i[w_sel];

  // A read may issue into a full FIFO when a response frees a slot this cycle.
  assign w_can_issue = w_sel_we | (r_count < MaxCnt) |
                       (cache_rvalid_i & (r_count != '0));

  assign cache_req_o = w_any & w_can_issue & ~rst_i;
  assign w_hs        = cache_req_o & cache_gnt_i;
  assign w_push      = w_hs & ~w_sel_we;
  assign w_pop       = cache_rvalid_i & (r_count != '0) & ~rst_i;

  assign cache_we_o    = w_any & w_sel_we;
  assign cache_index_o = w_any ? req_index_i[w_sel*IdxW +: IdxW]   : '0;
  assign cache_tag_o   = w_any ? req_tag_i[w_sel*TagW +: TagW]     : '0;
  assign cache_wdata_o = w_any ? req_wdata_i[w_sel*DataW +: DataW] : '0;
  assign cache_be_o    = w_any ? req_be_i[w_sel*BeW +: BeW]        : '0;

  always_comb begin
    req_gnt_o    = '0;
    req_rvalid_o = '0;
    if (w_hs)  req_gnt_o[w_sel]           = 1'b1;
    if (w_pop) req_rvalid_o[r_fifo[r_rptr]] = 1'b1;
  end

  assign req_rdata_o = cache_rdata_i;
  assign rsp_err_o   = r_rsp_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr  <= '0;
      r_lock    <= 1'b0;
      r_owner   <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      // A response with nothing pending is dropped and flagged.
      r_rsp_err <= cache_rvalid_i & (r_count == '0);

      if (w_hs) begin
        r_lock <= 1'b0;
      end else if (cache_req_o) begin
        r_lock  <= 1'b1;
        r_owner <= w_sel;
      end

      if ((RoundRobin != 0) && w_hs) begin
        r_rr_ptr <= (w_sel == LastIdx) ? '0 : w_sel + 1'b1;
      end

      if (w_push) r_wptr <= (r_wptr == LastPtr) ? '0 : r_wptr + 1'b1;
      if (w_pop)  r_rptr <= (r_rptr == LastPtr) ? '0 : r_rptr + 1'b1;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ID storage needs no reset: entries are only read when count > 0.
  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo[r_wptr] <= w_sel;
  end

  // A locked requester must keep its request up until it is granted.
  a_lock_hold: assert property (@(posedge clk_i) disable iff (rst_i)
                                r_lock |-> req_valid_i[r_owner]);

endmodule

// File: tb/tb_dcache_port_arbiter.sv
module tb_dcache_port_arbiter;

   localparam int NA = 3;
   localparam int NB = 2;

   logic clk = 1'b0;
   logic rstA = 1'b1;
   logic rstB = 1'b1;

   always #5 clk = ~clk;

   // Instance A: round-robin, three requesters
   logic [NA-1:0]      aValid = '0, aWe = '0;
   logic [NA*12-1:0]   aIndex = '0;
   logic [NA*44-1:0]   aTag = '0;
   logic [NA*64-1:0]   aWdata = '0;
   logic [NA*8-1:0]    aBe = '0;
   logic [NA-1:0]      gntA, rvalidA;
   logic [63:0]        rdataA;
   logic               cacheReqA, cacheWeA, errA;
   logic [11:0]        cacheIndexA;
   logic [43:0]        cacheTagA;
   logic [63:0]        cacheWdataA;
   logic [7:0]         cacheBeA;
   logic               cacheGntA = 1'b0, cacheRvalidA = 1'b0;
   logic [63:0]        cacheRdataA = '0;

   // Instance B: fixed priority, two requesters
   logic [NB-1:0]      bValid = '0, bWe = '0;
   logic [NB*12-1:0]   bIndex = '0;
   logic [NB*44-1:0]   bTag = '0;
   logic [NB*64-1:0]   bWdata = '0;
   logic [NB*8-1:0]    bBe = '0;
   logic [NB-1:0]      gntB, rvalidB;
   logic [63:0]        rdataB;
   logic               cacheReqB, cacheWeB, errB;
   logic [11:0]        cacheIndexB;
   logic [43:0]        cacheTagB;
   logic [63:0]        cacheWdataB;
   logic [7:0]         cacheBeB;
   logic               cacheGntB = 1'b0, cacheRvalidB = 1'b0;
   logic [63:0]        cacheRdataB = '0;

   dcache_port_arbiter #(.NumReq(NA), .RoundRobin(1), .MaxOutstanding(4)) dutA (
      .clk_i(clk), .rst_i(rstA),
      .req_valid_i(aValid), .req_we_i(aWe), .req_index_i(aIndex), .req_tag_i(aTag),
      .req_wdata_i(aWdata), .req_be_i(aBe),
      .req_gnt_o(gntA), .req_rvalid_o(rvalidA), .req_rdata_o(rdataA),
      .cache_req_o(cacheReqA), .cache_we_o(cacheWeA), .cache_index_o(cacheIndexA),
      .cache_tag_o(cacheTagA), .cache_wdata_o(cacheWdataA), .cache_be_o(cacheBeA),
      .cache_gnt_i(cacheGntA), .cache_rvalid_i(cacheRvalidA), .cache_rdata_i(cacheRdataA),
      .rsp_err_o(errA)
   );

   dcache_port_arbiter #(.NumReq(NB), .RoundRobin(0), .MaxOutstanding(4)) dutB (
      .clk_i(clk), .rst_i(rstB),
      .req_valid_i(bValid), .req_we_i(bWe), .req_index_i(bIndex), .req_tag_i(bTag),
      .req_wdata_i(bWdata), .req_be_i(bBe),
      .req_gnt_o(gntB), .req_rvalid_o(rvalidB), .req_rdata_o(rdataB),
      .cache_req_o(cacheReqB), .cache_we_o(cacheWeB), .cache_index_o(cacheIndexB),
      .cache_tag_o(cacheTagB), .cache_wdata_o(cacheWdataB), .cache_be_o(cacheBeB),
      .cache_gnt_i(cacheGntB), .cache_rvalid_i(cacheRvalidB), .cache_rdata_i(cacheRdataB),
      .rsp_err_o(errB)
   );

   int passCount = 0;
   int totalCount = 0;

   // Reference model state for instance A: grant lock, round-robin start
   // point, queue of requester ids awaiting read data, pending error pulse.
   bit mLock = 0;
   int mOwner = 0;
   int mPtr = 0;
   int mQ[$];
   bit mErr = 0;

   // Values observed at the most recent sample point of instance A.
   logic [NA-1:0] obsGntA, obsRvA;
   logic [63:0]   obsRdataA;
   logic [11:0]   obsIndexA;
   logic          obsReqA, obsErrA;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      totalCount++;
      assert (obs === exp) passCount++;
      else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // One clock of instance A: predict from the current inputs, compare at the
   // falling edge, then advance the model to match the rising edge.
   task automatic applyStimulus();
      int win, sel, qs;
      bit any, found, canIss, creq, hs, errNext;
      logic [NA-1:0] expGnt, expRv;
      any = |aValid;
      qs = mQ.size();
      win = 0;
      found = 0;
      for (int k = 0; k < NA; k++) begin
         int idx;
         idx = (mPtr + k) % NA;
         if (aValid[idx] && !found) begin
            win = idx;
            found = 1;
         end
      end
      sel = mLock ? mOwner : win;
      canIss = aWe[sel] || (qs < 4) || (cacheRvalidA && qs > 0);
      creq = any && canIss;
      hs = creq && cacheGntA;
      expGnt = hs ? NA'(1 << sel) : '0;
      expRv = (cacheRvalidA && qs > 0) ? NA'(1 << mQ[0]) : '0;
      @(negedge clk);
      checkOutput("cache_req", 64'(cacheReqA), 64'(creq));
      checkOutput("gnt", 64'(gntA), 64'(expGnt));
      checkOutput("rvalid", 64'(rvalidA), 64'(expRv));
      checkOutput("rdata", rdataA, cacheRdataA);
      checkOutput("rsp_err", 64'(errA), 64'(mErr));
      checkOutput("we", 64'(cacheWeA), any ? 64'(aWe[sel]) : 64'd0);
      checkOutput("index", 64'(cacheIndexA), any ? 64'(aIndex[sel*12 +: 12]) : 64'd0);
      checkOutput("tag", 64'(cacheTagA), any ? 64'(aTag[sel*44 +: 44]) : 64'd0);
      checkOutput("wdata", cacheWdataA, any ? aWdata[sel*64 +: 64] : 64'd0);
      checkOutput("be", 64'(cacheBeA), any ? 64'(aBe[sel*8 +: 8]) : 64'd0);
      obsGntA = gntA;
      obsRvA = rvalidA;
      obsRdataA = rdataA;
      obsIndexA = cacheIndexA;
      obsReqA = cacheReqA;
      obsErrA = errA;
      errNext = cacheRvalidA && (qs == 0);
      if (cacheRvalidA && qs > 0) void'(mQ.pop_front());
      if (hs && !aWe[sel]) mQ.push_back(sel);
      if (hs) begin
         mLock = 0;
         mPtr = (sel + 1) % NA;
      end else if (creq) begin
         mLock = 1;
         mOwner = sel;
      end
      mErr = errNext;
      @(posedge clk);
      #1;
   endtask

   task automatic resetA();
      rstA = 1'b1;
      aValid = '0;
      aWe = '0;
      cacheGntA = 1'b0;
      cacheRvalidA = 1'b0;
      @(posedge clk);
      #1;
      rstA = 1'b0;
      mLock = 0;
      mOwner = 0;
      mPtr = 0;
      mQ.delete();
      mErr = 0;
   endtask

   task automatic newRequest(input int i);
      aValid[i] = 1'b1;
      aWe[i] = ($urandom_range(0, 2) == 0);
      aIndex[i*12 +: 12] = 12'($urandom);
      aTag[i*44 +: 44] = {12'($urandom), 32'($urandom)};
      aWdata[i*64 +: 64] = {$urandom, $urandom};
      aBe[i*8 +: 8] = 8'($urandom);
   endtask

   logic [NA-1:0] rrSeq [6];
   logic [NA-1:0] ordGnt [3];
   logic [63:0]   ordData [3];
   logic [11:0]   idx1;

   initial begin
      rrSeq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      ordGnt = '{3'b100, 3'b001, 3'b100};
      ordData = '{64'hAAAA_0000_0000_000A, 64'hBBBB_0000_0000_000B, 64'hCCCC_0000_0000_000C};

      // Reset state
      @(negedge clk);
      checkOutput("rst_req_a", 64'(cacheReqA), 64'd0);
      checkOutput("rst_err_a", 64'(errA), 64'd0);
      checkOutput("rst_req_b", 64'(cacheReqB), 64'd0);
      @(posedge clk);
      #1;
      rstA = 1'b0;
      rstB = 1'b0;
      applyStimulus();

      // Fixed priority: requester 0 always wins until it drops
      for (int i = 0; i < NB; i++) begin
         bIndex[i*12 +: 12] = 12'($urandom);
         bTag[i*44 +: 44] = {12'($urandom), 32'($urandom)};
      end
      bValid = 2'b11;
      bWe = 2'b11;
      cacheGntB = 1'b1;
      repeat (4) begin
         @(negedge clk);
         checkOutput("fixed_gnt", 64'(gntB), 64'd1);
         checkOutput("fixed_index", 64'(cacheIndexB), 64'(bIndex[11:0]));
         @(posedge clk);
         #1;
      end
      bValid = 2'b10;
      @(negedge clk);
      checkOutput("fixed_gnt_r1", 64'(gntB), 64'd2);
      checkOutput("fixed_index_r1", 64'(cacheIndexB), 64'(bIndex[23:12]));
      checkOutput("fixed_rvalid", 64'(rvalidB), 64'd0);
      @(posedge clk);
      #1;
      // Fixed priority still honours a lock held by requester 1
      cacheGntB = 1'b0;
      @(posedge clk);
      #1;
      bValid = 2'b11;
      @(negedge clk);
      checkOutput("fixed_lock_index", 64'(cacheIndexB), 64'(bIndex[23:12]));
      @(posedge clk);
      #1;
      cacheGntB = 1'b1;
      @(negedge clk);
      checkOutput("fixed_lock_gnt", 64'(gntB), 64'd2);
      @(posedge clk);
      #1;
      bValid = 2'b00;
      cacheGntB = 1'b0;

      // Round-robin rotation with all requesters writing
      resetA();
      for (int i = 0; i < NA; i++) newRequest(i);
      aWe = 3'b111;
      cacheGntA = 1'b1;
      for (int c = 0; c < 6; c++) begin
         applyStimulus();
         checkOutput("rr_seq", 64'(obsGntA), 64'(rrSeq[c]));
      end

      // Lock: stalled requester 1 keeps the port when requester 0 arrives
      resetA();
      newRequest(1);
      newRequest(0);
      aValid = 3'b010;
      aWe = 3'b000;
      idx1 = aIndex[23:12];
      repeat (3) begin
         applyStimulus();
         checkOutput("lock_stall_index", 64'(obsIndexA), 64'(idx1));
         checkOutput("lock_stall_gnt", 64'(obsGntA), 64'd0);
      end
      aValid = 3'b011;
      applyStimulus();
      checkOutput("lock_hold_index", 64'(obsIndexA), 64'(idx1));
      cacheGntA = 1'b1;
      applyStimulus();
      checkOutput("lock_gnt_first", 64'(obsGntA), 64'b010);
      aValid = 3'b001;
      applyStimulus();
      checkOutput("lock_gnt_second", 64'(obsGntA), 64'b001);

      // Response ordering: reads from 2, 0, 2
      resetA();
      aWe = 3'b000;
      cacheGntA = 1'b1;
      aValid = 3'b100;
      applyStimulus();
      aValid = 3'b001;
      applyStimulus();
      aValid = 3'b100;
      applyStimulus();
      aValid = 3'b000;
      cacheRvalidA = 1'b1;
      for (int c = 0; c < 3; c++) begin
         cacheRdataA = ordData[c];
         applyStimulus();
         checkOutput("order_rvalid", 64'(obsRvA), 64'(ordGnt[c]));
         checkOutput("order_rdata", obsRdataA, ordData[c]);
      end
      cacheRvalidA = 1'b0;

      // FIFO full: fifth read waits for a response, then push and pop together
      resetA();
      newRequest(0);
      aWe = 3'b000;
      cacheGntA = 1'b1;
      repeat (4) applyStimulus();
      repeat (2) begin
         applyStimulus();
         checkOutput("full_blocked", 64'(obsReqA), 64'd0);
      end
      cacheRvalidA = 1'b1;
      applyStimulus();
      checkOutput("full_pushpop_req", 64'(obsReqA), 64'd1);
      checkOutput("full_pushpop_rv", 64'(obsRvA), 64'b001);
      cacheRvalidA = 1'b0;
      applyStimulus();
      checkOutput("full_still_full", 64'(obsReqA), 64'd0);

      // Reset with reads outstanding, then a stray response
      resetA();
      newRequest(0);
      aWe = 3'b000;
      cacheGntA = 1'b1;
      repeat (2) applyStimulus();
      cacheRvalidA = 1'b1;
      #2;
      rstA = 1'b1;
      #1;
      checkOutput("inrst_req", 64'(cacheReqA), 64'd0);
      checkOutput("inrst_gnt", 64'(gntA), 64'd0);
      checkOutput("inrst_rvalid", 64'(rvalidA), 64'd0);
      @(posedge clk);
      #1;
      rstA = 1'b0;
      mLock = 0;
      mOwner = 0;
      mPtr = 0;
      mQ.delete();
      mErr = 0;
      aValid = 3'b000;
      cacheGntA = 1'b0;
      applyStimulus();
      checkOutput("stray_rvalid", 64'(obsRvA), 64'd0);
      cacheRvalidA = 1'b0;
      applyStimulus();
      checkOutput("stray_err_pulse", 64'(obsErrA), 64'd1);
      applyStimulus();
      checkOutput("stray_err_clear", 64'(obsErrA), 64'd0);

      // Randomized traffic against the model
      resetA();
      repeat (400) begin
         for (int i = 0; i < NA; i++) begin
            if (!aValid[i] && $urandom_range(0, 2) == 0) newRequest(i);
         end
         cacheGntA = ($urandom_range(0, 3) != 0);
         cacheRvalidA = (mQ.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
         cacheRdataA = {$urandom, $urandom};
         applyStimulus();
         aValid = aValid & ~obsGntA;
      end

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
